// File: rtl/saradc_sequencer_if.sv
// Signal bundle between the conversion sequencer, the saradc and the host.
// The master side is the sequencer; the slave side is the ADC/host environment.
interface saradc_sequencer_if #(
   parameter int NBits = 5
);
   logic             enable;
   logic             trigger;
   logic             clearErr;
   logic             nEndCnv;
   logic [NBits-1:0] adcData;
   logic             nStartCnv;
   logic [NBits-1:0] sampleOut;
   logic             sampleValid;
   logic             busy;
   logic             timeoutErr;

   modport master (
      input  enable, trigger, clearErr, nEndCnv, adcData,
      output nStartCnv, sampleOut, sampleValid, busy, timeoutErr
   );

   modport slave (
      output enable, trigger, clearErr, nEndCnv, adcData,
      input  nStartCnv, sampleOut, sampleValid, busy, timeoutErr
   );
endinterface

// File: rtl/saradc_sequencer.sv
// Host-side saradc initiator: issues start requests, averages 2^AvgLog2 results
// per output sample and aborts conversions that stall beyond TimeoutCycles.
module saradc_sequencer #(
   parameter int NBits         = 5,
   parameter int AvgLog2       = 2,
   parameter int TimeoutCycles = 64,
   parameter int IdleGap       = 2
) (
   input  logic                clock,
   input  logic                reset,
   saradc_sequencer_if.master  bus
);
   localparam int AccW = NBits + AvgLog2;
   localparam int CntW = AvgLog2 + 1;
   localparam int ToW  = $clog2(TimeoutCycles + 1);
   localparam int GapW = $clog2(IdleGap + 1);
   localparam logic [CntW-1:0] BurstLen = CntW'(2 ** AvgLog2);
   localparam logic [ToW-1:0]  ToLast   = ToW'(TimeoutCycles - 1);
   localparam logic [GapW-1:0] GapLast  = GapW'(IdleGap - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      CONVERT = 3'd2,
      ACCUM   = 3'd3,
      GAP     = 3'd4
   } state_t;

   state_t          state_r, state_next_s;
   logic [AccW-1:0] acc_r;
   logic [CntW-1:0] scnt_r;
   logic [ToW-1:0]  tcnt_r;
   logic [GapW-1:0] gcnt_r;
   logic            aborted_r, enable_block_r;
   logic            n_start_cnv_r, sample_valid_r, busy_r, timeout_err_r;
   logic [NBits-1:0] sample_out_r;
   logic            burst_start_s, capture_s, emit_s, abort_s, timeout_hit_s;

   assign timeout_hit_s = (tcnt_r == ToLast);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode and per-cycle datapath strobes.
   always_comb begin
      state_next_s  = state_r;
      burst_start_s = 1'b0;
      capture_s     = 1'b0;
      emit_s        = 1'b0;
      abort_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.trigger || (bus.enable && !enable_block_r)) begin
               state_next_s  = START;
               burst_start_s = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         START: begin
            // A stale high nEndCnv on entry counts as the acknowledge.
            if (bus.nEndCnv) begin
               state_next_s = CONVERT;
            end else if (timeout_hit_s) begin
               state_next_s = GAP;
               abort_s      = 1'b1;
            end else begin
               state_next_s = START;
            end
         end
         CONVERT: begin
            if (!bus.nEndCnv) begin
               state_next_s = ACCUM;
               capture_s    = 1'b1;
            end else if (timeout_hit_s) begin
               state_next_s = GAP;
               abort_s      = 1'b1;
            end else begin
               state_next_s = CONVERT;
            end
         end
         ACCUM: begin
            emit_s       = (scnt_r == BurstLen);
            state_next_s = GAP;
         end
         GAP: begin
            if (gcnt_r == GapLast) begin
               if (aborted_r) begin
                  state_next_s = IDLE;
               end else if (scnt_r != {CntW{1'b0}}) begin
                  state_next_s = START;
               end else if (bus.enable) begin
                  state_next_s = START;
               end else begin
                  state_next_s = IDLE;
               end
            end else begin
               state_next_s = GAP;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Accumulator, counters, sticky flags and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_r          <= {AccW{1'b0}};
         scnt_r         <= {CntW{1'b0}};
         tcnt_r         <= {ToW{1'b0}};
         gcnt_r         <= {GapW{1'b0}};
         aborted_r      <= 1'b0;
         enable_block_r <= 1'b0;
         n_start_cnv_r  <= 1'b1;
         sample_out_r   <= {NBits{1'b0}};
         sample_valid_r <= 1'b0;
         busy_r         <= 1'b0;
         timeout_err_r  <= 1'b0;
      end else begin
         tcnt_r <= (state_r == START || state_r == CONVERT) ? tcnt_r + ToW'(1) : {ToW{1'b0}};
         gcnt_r <= (state_r == GAP) ? gcnt_r + GapW'(1) : {GapW{1'b0}};

         if (burst_start_s || abort_s || emit_s) begin
            acc_r  <= {AccW{1'b0}};
            scnt_r <= {CntW{1'b0}};
         end else if (capture_s) begin
            acc_r  <= acc_r + AccW'(bus.adcData);
            scnt_r <= scnt_r + CntW'(1);
         end

         if (emit_s) begin
            sample_out_r <= acc_r[AccW-1:AvgLog2];
         end
         sample_valid_r <= emit_s;

         if (abort_s) begin
            aborted_r <= 1'b1;
         end else if (state_r == IDLE) begin
            aborted_r <= 1'b0;
         end

         // After an abort, continuous mode stays parked until enable drops or a trigger arrives.
         if (abort_s) begin
            enable_block_r <= 1'b1;
         end else if (!bus.enable || (state_r == IDLE && bus.trigger)) begin
            enable_block_r <= 1'b0;
         end

         if (abort_s) begin
            timeout_err_r <= 1'b1;
         end else if (bus.clearErr) begin
            timeout_err_r <= 1'b0;
         end

         n_start_cnv_r <= (state_next_s != START);
         busy_r        <= (state_next_s != IDLE);
      end
   end

   assign bus.nStartCnv   = n_start_cnv_r;
   assign bus.sampleOut   = sample_out_r;
   assign bus.sampleValid = sample_valid_r;
   assign bus.busy        = busy_r;
   assign bus.timeoutErr  = timeout_err_r;
endmodule

// File: tb/tb_saradc_sequencer.sv
// Bench for saradc_sequencer: a behavioural saradc drives the handshake, a reference
// model averages the delivered results and a monitor scores every sampleValid.
module tb_saradc_sequencer;
   localparam int NB    = 5;
   localparam int AVG   = 2;
   localparam int TO    = 64;
   localparam int GAP   = 2;
   localparam int BURST = 1 << AVG;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   saradc_sequencer_if #(.NBits(NB)) bus ();

   saradc_sequencer #(
      .NBits(NB), .AvgLog2(AVG), .TimeoutCycles(TO), .IdleGap(GAP)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int exp_q[$];
   int part[$];
   int data_q[$];
   int conv_cycles = 8;
   bit adc_hang    = 1'b0;
   bit adc_active  = 1'b0;
   int sv_count    = 0;
   int pulse_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: every BURST delivered results produce their truncated mean.
   function automatic void model_add(input int d);
      int sum;
      part.push_back(d);
      if (part.size() == BURST) begin
         sum = 0;
         foreach (part[i]) sum += part[i];
         exp_q.push_back(sum / BURST);
         part.delete();
      end
   endfunction

   // Behavioural saradc: ack one cycle after a start request, result after conv_cycles.
   initial begin
      int d;
      bus.nEndCnv = 1'b0;
      bus.adcData = '0;
      forever begin
         @(negedge clock);
         if (!adc_hang && bus.nStartCnv === 1'b0) begin
            adc_active = 1'b1;
            @(negedge clock);
            bus.nEndCnv = 1'b1;
            repeat (conv_cycles) @(negedge clock);
            d = (data_q.size() != 0) ? data_q.pop_front() : int'($urandom_range(0, 31));
            bus.adcData = NB'(d);
            bus.nEndCnv = 1'b0;
            if (!reset) model_add(d);
            adc_active = 1'b0;
         end
      end
   end

   // Monitor: scores sampleValid against the model and watches start-request spacing.
   logic prev_nstart = 1'b1;
   int   high_run    = 0;
   bit   seen_rise   = 1'b0;
   always @(negedge clock) begin
      if (bus.sampleValid === 1'b1) begin
         sv_count++;
         if (exp_q.size() == 0) check("sample_unexpected", exp_q.size(), 1);
         else check("sampleOut", bus.sampleOut, exp_q.pop_front());
      end
      if (bus.nStartCnv === 1'b0) begin
         if (prev_nstart) begin
            pulse_count++;
            if (seen_rise) check("idle_gap", int'(high_run >= GAP), 1);
         end
      end else begin
         if (!prev_nstart) begin
            seen_rise = 1'b1;
            high_run  = 0;
         end
         high_run++;
      end
      prev_nstart = bus.nStartCnv;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_trigger();
      bus.trigger = 1'b1;
      @(negedge clock);
      bus.trigger = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy !== 1'b0 && n < 3000) begin
         @(negedge clock);
         n++;
      end
      check(name, bus.busy, 0);
   endtask

   task automatic run_shot(input string name);
      int sv0 = sv_count;
      int p0  = pulse_count;
      pulse_trigger();
      wait_idle({name, "_idle"});
      check({name, "_valid_count"}, sv_count - sv0, 1);
      check({name, "_start_pulses"}, pulse_count - p0, BURST);
      check({name, "_exp_drained"}, exp_q.size(), 0);
      check({name, "_timeout_err"}, bus.timeoutErr, 0);
   endtask

   initial begin
      int sv0, p0, n;
      bus.enable   = 1'b0;
      bus.trigger  = 1'b0;
      bus.clearErr = 1'b0;
      tick(3);
      check("rst_nStartCnv", bus.nStartCnv, 1);
      check("rst_sampleOut", bus.sampleOut, 0);
      check("rst_sampleValid", bus.sampleValid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_timeoutErr", bus.timeoutErr, 0);
      reset = 1'b0;
      tick(2);

      data_q = {10, 11, 12, 13};
      run_shot("avg");
      check("avg_value", bus.sampleOut, 11);
      data_q = {31, 31, 31, 31};
      run_shot("full");
      check("full_value", bus.sampleOut, 31);
      data_q = {0, 0, 0, 0};
      run_shot("zero");
      check("zero_value", bus.sampleOut, 0);

      for (int i = 0; i < 5; i++) begin
         conv_cycles = int'($urandom_range(1, 10));
         run_shot("rand");
      end
      conv_cycles = 8;

      // trigger while busy is dropped
      sv0 = sv_count;
      pulse_trigger();
      tick(20);
      check("busy_mid_burst", bus.busy, 1);
      pulse_trigger();
      wait_idle("retrig_idle");
      check("retrig_single_burst", sv_count - sv0, 1);

      // trigger coincident with enable
      sv0 = sv_count;
      bus.enable  = 1'b1;
      bus.trigger = 1'b1;
      tick(1);
      bus.enable  = 1'b0;
      bus.trigger = 1'b0;
      wait_idle("coinc_idle");
      check("coinc_single_burst", sv_count - sv0, 1);

      // continuous mode, enable dropped during burst 3
      sv0 = sv_count;
      bus.enable = 1'b1;
      n = 0;
      while (sv_count - sv0 < 2 && n < 2000) begin tick(1); n++; end
      n = 0;
      while (bus.nStartCnv !== 1'b0 && n < 100) begin tick(1); n++; end
      check("cont_burst3_started", bus.nStartCnv, 0);
      bus.enable = 1'b0;
      wait_idle("cont_idle");
      check("cont_three_bursts", sv_count - sv0, 3);
      check("cont_timeout_err", bus.timeoutErr, 0);

      // timeout: the ADC never acknowledges
      sv0 = sv_count;
      adc_hang   = 1'b1;
      bus.enable = 1'b1;
      n = 0;
      while (bus.nStartCnv !== 1'b0 && n < 100) begin tick(1); n++; end
      n = 0;
      while (bus.nStartCnv === 1'b0 && n < 200) begin tick(1); n++; end
      check("timeout_low_cycles", n, TO);
      wait_idle("timeout_idle");
      check("timeout_err_set", bus.timeoutErr, 1);
      p0 = pulse_count;
      tick(10);
      check("timeout_stays_idle", bus.busy, 0);
      check("timeout_no_restart", pulse_count - p0, 0);
      check("timeout_no_valid", sv_count - sv0, 0);
      bus.clearErr = 1'b1;
      tick(1);
      bus.clearErr = 1'b0;
      check("timeout_err_cleared", bus.timeoutErr, 0);
      bus.enable = 1'b0;
      adc_hang   = 1'b0;
      tick(2);

      // reset while a conversion is in flight with two samples accumulated
      sv0 = sv_count;
      data_q = {30, 30, 30};
      pulse_trigger();
      n = 0;
      while (part.size() < 2 && n < 2000) begin tick(1); n++; end
      n = 0;
      while (bus.nEndCnv !== 1'b1 && n < 100) begin tick(1); n++; end
      check("rst_mid_partial", part.size(), 2);
      reset = 1'b1;
      tick(1);
      check("rst_mid_nStartCnv", bus.nStartCnv, 1);
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_sampleOut", bus.sampleOut, 0);
      n = 0;
      while (adc_active && n < 100) begin tick(1); n++; end
      part.delete();
      data_q.delete();
      reset = 1'b0;
      tick(2);
      data_q = {3, 4, 5, 6};
      run_shot("post_reset");
      check("post_reset_value", bus.sampleOut, 4);
      check("post_reset_total_valid", sv_count - sv0, 1);

      tick(5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/saradc_sequencer.md
Name: saradc_sequencer

Overview:
Host-side initiator for the saradc conversion controller. It drives nStartCnv, tracks the nEndCnv handshake, and captures each dataOut result. It averages 2^AvgLog2 conversions into one output sample and flags stalled conversions with a timeout. It runs in single-shot mode (trigger) or continuous mode (enable).

Parameters:
NBits, 5, ADC result width; must match the connected saradc.
AvgLog2, 2, log2 of the number of conversions averaged per output sample (0 = no averaging).
TimeoutCycles, 64, maximum cycles allowed in START or CONVERT before the conversion is aborted.
IdleGap, 2, cycles with nStartCnv held high between conversions (minimum 1).

Ports:
clock  in  1  system clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  continuous mode; bursts repeat while this is high.
trigger  in  1  single-cycle pulse; starts one averaged burst from IDLE.
clearErr  in  1  clears timeoutErr.
nEndCnv  in  1  from saradc; high = conversion in progress (acknowledge), low = result ready or idle.
adcData  in  NBits  from saradc dataOut; valid when nEndCnv returns low.
nStartCnv  out  1  to saradc; active-low start request.
sampleOut  out  NBits  averaged result.
sampleValid  out  1  one-cycle pulse when sampleOut updates.
busy  out  1  high whenever state != IDLE.
timeoutErr  out  1  sticky abort flag.

Behaviour:
- Reset: synchronous, active-high, takes priority over all other inputs. It forces state IDLE, nStartCnv=1, sampleOut=0, sampleValid=0, busy=0, timeoutErr=0, and clears the accumulator, sample counter, timeout counter and gap counter. Reset asserted mid-conversion gives nStartCnv=1 on the next edge. The partial burst is discarded and no sampleValid is produced.
- All outputs are registered. nStartCnv is low exactly while state==START.
- State IDLE:
  - If enable=1 or trigger=1 is sampled, go to START and clear the accumulator and sample counter.
  - If enable and trigger are both high, treat as a single start.
- State START:
  - Hold nStartCnv=0 and wait for nEndCnv==1 (acknowledge).
  - On acknowledge, go to CONVERT; nStartCnv=1 from the next cycle.
  - Timeout counter increments each cycle in this state.
- State CONVERT:
  - Wait for nEndCnv==0.
  - On that edge, capture adcData into the accumulator (acc += adcData), increment the sample counter, and go to ACCUM.
  - Timeout counter continues and is not reset on entering CONVERT.
- State ACCUM (one cycle):
  - If sample counter == 2^AvgLog2: sampleOut <= acc[NBits+AvgLog2-1:AvgLog2] (truncating divide), sampleValid=1 for this cycle, clear the accumulator and sample counter.
  - Go to GAP in all cases.
- State GAP:
  - Hold for IdleGap cycles.
  - Then: if a burst is incomplete, go to START.
  - Else if enable=1, go to START (new burst).
  - Else go to IDLE.
- Timeout counter clears on entry to START. Abort occurs when the counter reaches TimeoutCycles while in START or CONVERT. On abort:
  - timeoutErr <= 1.
  - nStartCnv=1.
  - Accumulator and sample counter cleared; no sampleValid.
  - Go to GAP, then IDLE regardless of enable. Re-entry requires enable to be deasserted and reasserted, or a trigger.
- Accumulator width is NBits+AvgLog2 and cannot overflow (max = (2^NBits-1)*2^AvgLog2).
- trigger is ignored outside IDLE and is not queued.
- enable deasserted mid-burst: the current burst completes, then the block returns to IDLE.
- clearErr clears timeoutErr. If clearErr coincides with a new abort, set wins (timeoutErr=1).
- nEndCnv already high on entry to START (stale acknowledge) counts as an acknowledge.
- Latency from nEndCnv falling to sampleValid (final conversion of a burst): 2 cycles (CONVERT capture edge, then ACCUM output edge).

Test Plan:
- Single-shot average, AvgLog2=2: trigger pulse; ADC model acks 1 cycle after nStartCnv low and returns 10,11,12,13 after 8 cycles each -> four nStartCnv low pulses, exactly one sampleValid with sampleOut=11, busy falls after the gap, timeoutErr=0.
- Full-scale, no overflow: ADC returns 31 four times -> sampleOut=31. ADC returns 0 four times -> sampleOut=0.
- Timeout: ADC never acks; enable=1 -> nStartCnv low for 64 cycles then high, timeoutErr=1, no sampleValid, state returns to IDLE with enable still high. Pulse clearErr -> timeoutErr=0.
- Continuous mode: enable=1 for 3 bursts, then deasserted during burst 3 -> 3 sampleValid pulses, at least IdleGap cycles of nStartCnv=1 between conversions, IDLE after burst 3.
- Reset mid-CONVERT: assert reset while nEndCnv=1 after 2 samples accumulated -> next edge gives nStartCnv=1, busy=0, sampleOut=0. A fresh trigger then yields the correct average of 4 new samples only.
- trigger while busy and trigger coincident with enable -> ignored / single burst; sampleValid count matches bursts started.
